alu_multicycle: RTL and testbench

Parametrised, registered ALU with a valid/ready handshake on both sides and status flags. It executes the single-cycle operation set (MOV/NOT/ADD/SUB/OR/AND/SLT), adds unsigned compare, shifts and an iterative shift-add multiply. It sits between the register-file read stage and the write-back stage of the lab datapath. Results are held stable until the consumer accepts them.

---
 rtl/alu_multicycle.sv | 222 ++++++++++++++++++++++
 tb/tb_alu_multicycle.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// Registered ALU with valid/ready handshakes on both sides and status flags.
// MUL runs as WIDTH shift-add steps; every other opcode completes in one cycle.
module alu_multicycle #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       ALUOp,
   input  logic [WIDTH-1:0] R2,
   input  logic [WIDTH-1:0] R3,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] R1,
   output logic             zero,
   output logic             neg,
   output logic             carry,
   output logic             ovf,
   output logic             illegal
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [3:0] OP_MOV  = 4'd0;
   localparam logic [3:0] OP_NOT  = 4'd1;
   localparam logic [3:0] OP_ADD  = 4'd2;
   localparam logic [3:0] OP_SUB  = 4'd3;
   localparam logic [3:0] OP_OR   = 4'd4;
   localparam logic [3:0] OP_AND  = 4'd5;
   localparam logic [3:0] OP_SLT  = 4'd6;
   localparam logic [3:0] OP_SLTU = 4'd7;
   localparam logic [3:0] OP_SLL  = 4'd8;
   localparam logic [3:0] OP_SRL  = 4'd9;
   localparam logic [3:0] OP_SRA  = 4'd10;
   localparam logic [3:0] OP_MUL  = 4'd11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_e;

   state_e           state_q,     state_d;
   logic [CW-1:0]    count_q,     count_d;
   logic [WIDTH-1:0] acc_q,       acc_d;
   logic [WIDTH-1:0] mcand_q,     mcand_d;
   logic [WIDTH-1:0] mplier_q,    mplier_d;
   logic [WIDTH-1:0] r1_q,        r1_d;
   logic             zero_q,      zero_d;
   logic             neg_q,       neg_d;
   logic             carry_q,     carry_d;
   logic             ovf_q,       ovf_d;
   logic             illegal_q,   illegal_d;
   logic             out_valid_q, out_valid_d;

   logic             accept;
   logic [SHW-1:0]   shamt;
   logic [WIDTH:0]   sum_ext;
   logic [WIDTH-1:0] alu_res;
   logic             alu_carry;
   logic             alu_ovf;
   logic             alu_illegal;
   logic [WIDTH-1:0] acc_step;

   assign shamt = R3[SHW-1:0];

   // Single-cycle result of the operands currently on the input port.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      alu_res     = '0;
      alu_carry   = 1'b0;
      alu_ovf     = 1'b0;
      alu_illegal = 1'b0;
      sum_ext     = '0;
      case (ALUOp)
         OP_MOV:  alu_res = R2;
         OP_NOT:  alu_res = ~R2;
         OP_ADD: begin
            sum_ext   = {1'b0, R2} + {1'b0, R3} + {{WIDTH{1'b0}}, c_in};
            alu_res   = sum_ext[WIDTH-1:0];
            alu_carry = sum_ext[WIDTH];
            alu_ovf   = (R2[WIDTH-1] == R3[WIDTH-1]) && (alu_res[WIDTH-1] != R2[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res   = R2 - R3;
            alu_carry = (R2 < R3);
            alu_ovf   = (R2[WIDTH-1] != R3[WIDTH-1]) && (alu_res[WIDTH-1] != R2[WIDTH-1]);
         end
         OP_OR:   alu_res = R2 | R3;
         OP_AND:  alu_res = R2 & R3;
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(R2) < $signed(R3))};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (R2 < R3)};
         OP_SLL:  alu_res = R2 << shamt;
         OP_SRL:  alu_res = R2 >> shamt;
         OP_SRA:  alu_res = $signed(R2) >>> shamt;
         OP_MUL:  alu_res = '0;
         default: alu_illegal = 1'b1;
      endcase
   end

   // Multiplier bit 0 selects whether the shifted multiplicand joins the sum.
   assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

   always_comb begin
      in_ready = 1'b0;
      if (!reset) begin
         case (state_q)
            S_IDLE:  in_ready = 1'b1;
            S_DONE:  in_ready = out_ready;
            default: in_ready = 1'b0;
         endcase
      end
   end

   assign accept = in_valid && in_ready;

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      acc_d       = acc_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      r1_d        = r1_q;
      zero_d      = zero_q;
      neg_d       = neg_q;
      carry_d     = carry_q;
      ovf_d       = ovf_q;
      illegal_d   = illegal_q;
      out_valid_d = out_valid_q;

      case (state_q)
         S_BUSY: begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q - CW'(1);
            if (count_q == CW'(1)) begin
               state_d     = S_DONE;
               out_valid_d = 1'b1;
               r1_d        = acc_step;
               zero_d      = (acc_step == '0);
               neg_d       = acc_step[WIDTH-1];
               carry_d     = 1'b0;
               ovf_d       = 1'b0;
               illegal_d   = 1'b0;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d     = S_IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: ;
      endcase

      // A new accept overrides the retire path, giving back-to-back issue from DONE.
      if (accept) begin
         if (ALUOp == OP_MUL) begin
            state_d     = S_BUSY;
            count_d     = CW'(WIDTH);
            acc_d       = '0;
            mcand_d     = R2;
            mplier_d    = R3;
            out_valid_d = 1'b0;
         end else begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            r1_d        = alu_res;
            zero_d      = (alu_res == '0);
            neg_d       = alu_res[WIDTH-1];
            carry_d     = alu_carry;
            ovf_d       = alu_ovf;
            illegal_d   = alu_illegal;
         end
      end
   end

   always_ff @(posedge clock) begin
      // NOTE: the multiply datapath registers are reset too, so a MUL cut short leaves nothing behind.
      if (reset) begin
         state_q     <= S_IDLE;
         count_q     <= '0;
         acc_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         r1_q        <= '0;
         zero_q      <= 1'b0;
         neg_q       <= 1'b0;
         carry_q     <= 1'b0;
         ovf_q       <= 1'b0;
         illegal_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge value of every other flop.
         state_q     <= state_d;
         count_q     <= count_d;
         acc_q       <= acc_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         r1_q        <= r1_d;
         zero_q      <= zero_d;
         neg_q       <= neg_d;
         carry_q     <= carry_d;
         ovf_q       <= ovf_d;
         illegal_q   <= illegal_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid = out_valid_q;
   assign R1        = r1_q;
   assign zero      = zero_q;
   assign neg       = neg_q;
   assign carry     = carry_q;
   assign ovf       = ovf_q;
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle at WIDTH=8 with a queue-based result model.
module tb_alu_multicycle;

   localparam int W = 8;

   logic         clock = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   ALUOp;
   logic [W-1:0] R2;
   logic [W-1:0] R3;
   logic         c_in;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] R1;
   logic         zero, neg, carry, ovf, illegal;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic [7:0] r1;
      logic [4:0] f;   // {zero, neg, carry, ovf, illegal}
   } exp_t;

   typedef struct packed {
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic       ci;
      logic [7:0] r1;
      logic [4:0] f;
   } vec_t;

   exp_t exp_q[$];

   alu_multicycle #(.WIDTH(W)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ALUOp     (ALUOp),
      .R2        (R2),
      .R3        (R3),
      .c_in      (c_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .R1        (R1),
      .zero      (zero),
      .neg       (neg),
      .carry     (carry),
      .ovf       (ovf),
      .illegal   (illegal)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Plain integer arithmetic over the opcode table; result wraps to 8 bits.
   function automatic exp_t model(input logic [3:0] op, input logic [7:0] a,
                                  input logic [7:0] b, input logic ci);
      int ua, ub, sa, sb, c, sh, r, s;
      logic cy, ov, il;
      logic [7:0] res;
      exp_t e;
      ua = int'(a);
      ub = int'(b);
      sa = int'($signed(a));
      sb = int'($signed(b));
      c  = int'(ci);
      sh = ub % 8;
      r  = 0;
      cy = 1'b0;
      ov = 1'b0;
      il = 1'b0;
      case (op)
         4'd0:  r = ua;
         4'd1:  r = ~ua;
         4'd2: begin
            r  = ua + ub + c;
            cy = (r > 255);
            s  = sa + sb + c;
            ov = (s > 127) || (s < -128);
         end
         4'd3: begin
            r  = ua - ub;
            cy = (ua < ub);
            s  = sa - sb;
            ov = (s > 127) || (s < -128);
         end
         4'd4:  r = ua | ub;
         4'd5:  r = ua & ub;
         4'd6:  r = (sa < sb) ? 1 : 0;
         4'd7:  r = (ua < ub) ? 1 : 0;
         4'd8:  r = ua << sh;
         4'd9:  r = ua >> sh;
         4'd10: r = sa >>> sh;
         4'd11: r = ua * ub;
         default: begin
            r  = 0;
            il = 1'b1;
         end
      endcase
      res  = r[7:0];
      e.r1 = res;
      e.f  = {(res == 8'h00), res[7], cy, ov, il};
      return e;
   endfunction

   // Scoreboard: compare any presented result, then track the retire/accept of the coming edge.
   always @(negedge clock) begin
      if (out_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_unexpected_valid: got out_valid=1 with R1=0x%0h, required no pending result", R1);
         end else begin
            check("sb_r1",    64'(R1), 64'(exp_q[0].r1));
            check("sb_flags", 64'({zero, neg, carry, ovf, illegal}), 64'(exp_q[0].f));
         end
      end
      if (reset) begin
         exp_q.delete();
      end else begin
         if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
         if (in_valid && in_ready) exp_q.push_back(model(ALUOp, R2, R3, c_in));
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic ci);
      int waited;
      ALUOp    = op;
      R2       = a;
      R3       = b;
      c_in     = ci;
      in_valid = 1'b1;
      #1;
      waited = 0;
      while (!in_ready && waited < 20) begin
         tick();
         waited++;
      end
      if (!in_ready) begin
         n_tests++;
         n_fail++;
         $display("FAIL issue_timeout: in_ready stayed 0 for %0d cycles, required 1", waited);
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic mul_test(input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp_r1);
      issue(4'd11, a, b, 1'b0);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("mul_busy%0d_in_ready", i),  64'(in_ready),  64'(0));
         check($sformatf("mul_busy%0d_out_valid", i), 64'(out_valid), 64'(0));
         // Operand noise while busy must not be taken.
         in_valid = (i < 7);
         ALUOp    = 4'd2;
         R2       = 8'hAA;
         R3       = 8'(i);
         tick();
      end
      in_valid = 1'b0;
      check("mul_done_valid", 64'(out_valid), 64'(1));
      check("mul_r1",         64'(R1),        64'(exp_r1));
   endtask

   vec_t vecs [15] = '{
      '{4'd0,  8'h3C, 8'h00, 1'b0, 8'h3C, 5'b00000},
      '{4'd1,  8'h3C, 8'h00, 1'b0, 8'hC3, 5'b01000},
      '{4'd2,  8'h7F, 8'h01, 1'b0, 8'h80, 5'b01010},
      '{4'd2,  8'hFF, 8'h01, 1'b1, 8'h01, 5'b00100},
      '{4'd3,  8'h03, 8'h05, 1'b0, 8'hFE, 5'b01100},
      '{4'd3,  8'h05, 8'h05, 1'b1, 8'h00, 5'b10000},
      '{4'd3,  8'h80, 8'h01, 1'b0, 8'h7F, 5'b00010},
      '{4'd4,  8'hF0, 8'h0C, 1'b0, 8'hFC, 5'b01000},
      '{4'd5,  8'hF0, 8'h3C, 1'b0, 8'h30, 5'b00000},
      '{4'd6,  8'hFF, 8'h01, 1'b0, 8'h01, 5'b00000},
      '{4'd7,  8'hFF, 8'h01, 1'b0, 8'h00, 5'b10000},
      '{4'd8,  8'h81, 8'h0A, 1'b0, 8'h04, 5'b00000},
      '{4'd9,  8'h90, 8'h0B, 1'b0, 8'h12, 5'b00000},
      '{4'd10, 8'h90, 8'h0B, 1'b0, 8'hF2, 5'b01000},
      '{4'd13, 8'h55, 8'hAA, 1'b0, 8'h00, 5'b10001}
   };

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t m;
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      ALUOp     = 4'd0;
      R2        = '0;
      R3        = '0;
      c_in      = 1'b0;

      // Reset state.
      tick();
      check("rst_in_ready",  64'(in_ready),  64'(0));
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_r1",        64'(R1),        64'(0));
      check("rst_flags",     64'({zero, neg, carry, ovf, illegal}), 64'(0));
      tick();
      reset = 1'b0;
      #1;
      check("post_rst_in_ready", 64'(in_ready), 64'(1));

      // Single-cycle opcodes issued back to back with out_ready held high.
      for (int i = 0; i < 15; i++) begin
         m = model(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ci);
         check($sformatf("model_vec%0d", i), 64'(m), 64'({vecs[i].r1, vecs[i].f}));
         issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ci);
         check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(1));
         check($sformatf("vec%0d_r1", i),    64'(R1),        64'(vecs[i].r1));
         check($sformatf("vec%0d_flags", i), 64'({zero, neg, carry, ovf, illegal}), 64'(vecs[i].f));
      end

      // Multiply: latency, busy stall, and back-to-back MUL issue from DONE.
      m = model(4'd11, 8'd13, 8'd11, 1'b0);
      check("model_mul", 64'(m), 64'({8'h8F, 5'b01000}));
      mul_test(8'd13, 8'd11, 8'h8F);
      check("mul_flags", 64'({zero, neg, carry, ovf, illegal}), 64'(5'b01000));
      mul_test(8'hFF, 8'hFF, 8'h01);
      mul_test(8'h00, 8'h7B, 8'h00);
      check("mul_zero_flag", 64'(zero), 64'(1));

      // Backpressure: result held for five cycles while the input port churns.
      tick();
      out_ready = 1'b0;
      issue(4'd5, 8'hF0, 8'h3C, 1'b0);
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1;
         ALUOp    = 4'd2;
         R2       = 8'(k);
         R3       = 8'h01;
         #1;
         check($sformatf("bp%0d_valid", k),    64'(out_valid), 64'(1));
         check($sformatf("bp%0d_in_ready", k), 64'(in_ready),  64'(0));
         check($sformatf("bp%0d_r1", k),       64'(R1),        64'(8'h30));
         check($sformatf("bp%0d_flags", k),    64'({zero, neg, carry, ovf, illegal}), 64'(0));
         tick();
      end
      ALUOp     = 4'd2;
      R2        = 8'h01;
      R3        = 8'h02;
      c_in      = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      check("bp_release_in_ready", 64'(in_ready), 64'(1));
      tick();
      in_valid = 1'b0;
      check("bp_next_valid", 64'(out_valid), 64'(1));
      check("bp_next_r1",    64'(R1),        64'(8'h03));

      // Reset in the fourth cycle of a MUL discards it; a later ADD is unaffected.
      tick();
      issue(4'd11, 8'd13, 8'd11, 1'b0);
      tick();
      tick();
      tick();
      reset = 1'b1;
      tick();
      check("mid_rst_out_valid", 64'(out_valid), 64'(0));
      check("mid_rst_r1",        64'(R1),        64'(0));
      check("mid_rst_flags",     64'({zero, neg, carry, ovf, illegal}), 64'(0));
      check("mid_rst_in_ready",  64'(in_ready),  64'(0));
      reset = 1'b0;
      #1;
      check("mid_rst_idle", 64'(in_ready), 64'(1));
      issue(4'd2, 8'h05, 8'h06, 1'b1);
      check("after_rst_valid", 64'(out_valid), 64'(1));
      check("after_rst_r1",    64'(R1),        64'(8'h0C));

      tick();
      tick();
      check("sb_drained", 64'(exp_q.size()), 64'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
